// File: rtl/insmem_pkg.sv
// insmem_pkg: state encoding, depth derivation and parity helper shared by the
// loadable instruction memory and its loader.
package insmem_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  // Widest word the parity helper accepts; narrower words are zero-extended.
  localparam int PAR_MAX_W = 64;

  // Word depth addressed by a byte PC of pc_bits bits (bit 0 ignored).
  function automatic int insmem_depth(input int pc_bits);
    return 32'sd1 <<< (pc_bits - 32'sd1);
  endfunction

  // Zero padding does not change the XOR, so callers may widen any word.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/insmem_loader.sv
// insmem_loader: EMPTY/LOAD/RUN program-load FSM; owns the write pointer,
// program length, overflow flag and the storage write strobe/address.
module insmem_loader
  import insmem_pkg::*;
#(
  parameter int PC_BITS = 6
) (
  input  logic               clka,
  input  logic               rst_n,
  input  logic               load_start,
  input  logic               load_valid,
  input  logic               load_last,
  output logic               load_ready,
  output logic               load_busy,
  output logic               load_err,
  output logic [PC_BITS-1:0] prog_len,
  output state_e             state,
  output logic               wr_en,
  output logic [PC_BITS-2:0] wr_addr
);

  localparam int                 DEPTH     = insmem_depth(PC_BITS);
  localparam logic [PC_BITS-1:0] LAST_SLOT = PC_BITS'(DEPTH - 1);
  localparam logic [PC_BITS-1:0] FULL_LEN  = PC_BITS'(DEPTH);
  localparam logic [PC_BITS-1:0] ONE       = PC_BITS'(1);

  state_e             state_q, state_d;
  logic [PC_BITS-1:0] wptr_q, wptr_d;
  logic [PC_BITS-1:0] prog_len_q, prog_len_d;
  logic               load_err_q, load_err_d;
  logic               accept_s;

  // A restart pulse takes priority over a same-cycle word, which is dropped.
  assign load_ready = (state_q == ST_LOAD) && !load_start;
  assign accept_s   = load_ready && load_valid;
  assign wr_en      = accept_s;
  assign wr_addr    = wptr_q[PC_BITS-2:0];
  assign load_busy  = (state_q == ST_LOAD);
  assign load_err   = load_err_q;
  assign prog_len   = prog_len_q;
  assign state      = state_q;

  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    prog_len_d = prog_len_q;
    load_err_d = load_err_q;
    case (state_q)
      ST_EMPTY, ST_RUN: begin
        if (load_start) begin
          state_d    = ST_LOAD;
          wptr_d     = '0;
          prog_len_d = '0;
          load_err_d = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_LOAD: begin
        if (load_start) begin
          wptr_d = '0;
        end else if (load_valid) begin
          wptr_d = wptr_q + ONE;
          if (load_last) begin
            state_d    = ST_RUN;
            prog_len_d = wptr_q + ONE;
          end else if (wptr_q == LAST_SLOT) begin
            // Array full with no terminator: run what fits and flag it.
            state_d    = ST_RUN;
            prog_len_d = FULL_LEN;
            load_err_d = 1'b1;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      wptr_q     <= '0;
      prog_len_q <= '0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      prog_len_q <= prog_len_d;
      load_err_q <= load_err_d;
    end
  end

endmodule

// File: rtl/insmem_loadable.sv
// insmem_loadable: loadable instruction memory with bounds-checked registered fetch.
// Define INSMEM_PARITY_EN to store and check a per-word even-parity bit.
module insmem_loadable
  import insmem_pkg::*;
#(
  parameter int WORD_W  = 16,
  parameter int PC_BITS = 6
) (
  input  logic               clka,
  input  logic               rst_n,
  input  logic               load_start,
  input  logic               load_valid,
  input  logic [WORD_W-1:0]  load_data,
  input  logic               load_last,
  output logic               load_ready,
  output logic               load_busy,
  output logic               load_err,
  output logic [PC_BITS-1:0] prog_len,
  input  logic               fetch_en,
  input  logic [PC_BITS-1:0] pc,
  output logic [WORD_W-1:0]  instr_out,
  output logic               instr_valid,
  output logic               fetch_oob,
  input  logic               par_inject,
  output logic               parity_err
);

  localparam int DEPTH = insmem_depth(PC_BITS);

  logic [WORD_W-1:0]  mem [DEPTH];
  state_e             state_s;
  logic               wr_en_s;
  logic [PC_BITS-2:0] wr_addr_s;
  logic [PC_BITS-2:0] rd_idx_s;
  logic               run_s, in_bounds_s, hit_s, par_bad_s;
  logic               unused_pc0_s;

  logic [WORD_W-1:0]  instr_q, instr_d;
  logic               valid_q, valid_d;
  logic               oob_q, oob_d;
  logic               perr_q, perr_d;

  insmem_loader #(.PC_BITS(PC_BITS)) u_loader (
    .clka       (clka),
    .rst_n      (rst_n),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_last  (load_last),
    .load_ready (load_ready),
    .load_busy  (load_busy),
    .load_err   (load_err),
    .prog_len   (prog_len),
    .state      (state_s),
    .wr_en      (wr_en_s),
    .wr_addr    (wr_addr_s)
  );

  assign rd_idx_s     = pc[PC_BITS-1:1];
  assign unused_pc0_s = pc[0];
  assign run_s        = (state_s == ST_RUN);
  assign in_bounds_s  = ({1'b0, rd_idx_s} < prog_len);
  assign hit_s        = fetch_en && run_s && in_bounds_s;

  // Storage is intentionally not reset; prog_len gates what is reachable.
  always_ff @(posedge clka) begin
    if (wr_en_s) begin
      mem[wr_addr_s] <= load_data;
    end
  end

`ifdef INSMEM_PARITY_EN
  logic par_mem [DEPTH];

  always_ff @(posedge clka) begin
    if (wr_en_s) begin
      par_mem[wr_addr_s] <= even_parity(PAR_MAX_W'(load_data)) ^ par_inject;
    end
  end

  assign par_bad_s = (par_mem[rd_idx_s] != even_parity(PAR_MAX_W'(mem[rd_idx_s])));
`else
  logic unused_par_inject_s;

  assign unused_par_inject_s = par_inject;
  assign par_bad_s           = 1'b0;
`endif

  always_comb begin
    instr_d = '0;
    valid_d = fetch_en && run_s;
    oob_d   = fetch_en && run_s && !in_bounds_s;
    perr_d  = 1'b0;
    if (hit_s) begin
      instr_d = mem[rd_idx_s];
      perr_d  = par_bad_s;
    end else begin
      instr_d = '0;
    end
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= '0;
      valid_q <= 1'b0;
      oob_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      instr_q <= instr_d;
      valid_q <= valid_d;
      oob_q   <= oob_d;
      perr_q  <= perr_d;
    end
  end

  assign instr_out   = instr_q;
  assign instr_valid = valid_q;
  assign fetch_oob   = oob_q;
  assign parity_err  = perr_q;

endmodule

// File: tb/tb_insmem_loadable.sv
// Self-checking bench for insmem_loadable: scoreboarded fetches against a
// reference model of the loaded program, plus load-port status checks.
module tb_insmem_loadable;

  localparam int WORD_W  = 16;
  localparam int PC_BITS = 6;
  localparam int DEPTH   = 32;

  typedef struct {
    logic [WORD_W-1:0] instr;
    logic              valid;
    logic              oob;
    logic              perr;
  } exp_t;

  logic               clka = 1'b0;
  logic               rst_n = 1'b0;
  logic               load_start = 1'b0, load_valid = 1'b0, load_last = 1'b0;
  logic [WORD_W-1:0]  load_data = '0;
  logic               load_ready, load_busy, load_err;
  logic [PC_BITS-1:0] prog_len;
  logic               fetch_en = 1'b0;
  logic [PC_BITS-1:0] pc = '0;
  logic [WORD_W-1:0]  instr_out;
  logic               instr_valid, fetch_oob, parity_err;
  logic               par_inject = 1'b0;

  exp_t              sb[$];
  logic [WORD_W-1:0] model_mem [DEPTH];
  logic              model_pbad [DEPTH];
  int                model_len = 0;
  logic              model_run = 1'b0;
  int                n_cmp = 0, n_err = 0;

  always #5 clka = ~clka;

  insmem_loadable #(.WORD_W(WORD_W), .PC_BITS(PC_BITS)) dut (
    .clka(clka), .rst_n(rst_n), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
    .load_busy(load_busy), .load_err(load_err), .prog_len(prog_len),
    .fetch_en(fetch_en), .pc(pc), .instr_out(instr_out), .instr_valid(instr_valid),
    .fetch_oob(fetch_oob), .par_inject(par_inject), .parity_err(parity_err)
  );

  function automatic exp_t model_fetch(input logic [PC_BITS-1:0] p);
    exp_t e;
    int idx;
    idx = int'(p >> 1);
    e.instr = '0; e.valid = model_run; e.oob = 1'b0; e.perr = 1'b0;
    if (model_run) begin
      if (idx < model_len) begin
        e.instr = model_mem[idx];
        e.perr  = model_pbad[idx];
      end else begin
        e.oob = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    model_run  = 1'b0;
    model_len  = 0;
    tick();
    load_start = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    n_cmp++; if (load_ready !== 1'b0) begin n_err++; $display("FAIL reset_load_ready got=%b exp=0", load_ready); end
    n_cmp++; if (load_busy !== 1'b0) begin n_err++; $display("FAIL reset_load_busy got=%b exp=0", load_busy); end
    n_cmp++; if (load_err !== 1'b0) begin n_err++; $display("FAIL reset_load_err got=%b exp=0", load_err); end
    n_cmp++; if (prog_len !== 6'd0) begin n_err++; $display("FAIL reset_prog_len got=%0d exp=0", prog_len); end
    n_cmp++; if ({instr_out, instr_valid, fetch_oob, parity_err} !== 19'd0) begin
      n_err++; $display("FAIL reset_fetch_outs got=%h/%b/%b/%b exp=0", instr_out, instr_valid, fetch_oob, parity_err);
    end
  endtask

  task automatic test_reset_mid_load();
    exp_t e;
    start_load();
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1; load_data = WORD_W'(16'h0A00 + i); load_last = 1'b0;
      tick();
    end
    load_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    model_run = 1'b0; model_len = 0;
    n_cmp++; if (load_busy !== 1'b0) begin n_err++; $display("FAIL midreset_busy got=%b exp=0", load_busy); end
    n_cmp++; if (prog_len !== 6'd0) begin n_err++; $display("FAIL midreset_prog_len got=%0d exp=0", prog_len); end
    fetch_en = 1'b1; pc = 6'd0; sb.push_back(model_fetch(6'd0));
    tick();
    fetch_en = 1'b0;
    e = sb.pop_front();
    n_cmp++; if (instr_valid !== e.valid || instr_out !== e.instr) begin
      n_err++; $display("FAIL midreset_fetch got=%h/%b exp=%h/%b", instr_out, instr_valid, e.instr, e.valid);
    end
  endtask

  task automatic test_load4();
    logic [WORD_W-1:0] words [4];
    logic [PC_BITS-1:0] pcs [8];
    exp_t e;
    words = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    pcs   = '{6'd6, 6'd7, 6'd8, 6'd0, 6'd2, 6'd4, 6'd62, 6'd9};
    start_load();
    n_cmp++; if ({load_busy, load_ready} !== 2'b11) begin n_err++; $display("FAIL load4_busy_ready got=%b exp=11", {load_busy, load_ready}); end
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1; load_data = words[i]; load_last = (i == 3);
      model_mem[i] = words[i]; model_pbad[i] = 1'b0;
      if (i == 3) begin
        fetch_en = 1'b1; pc = 6'd0; sb.push_back(model_fetch(6'd0));
      end
      tick();
      if (i == 3) begin
        e = sb.pop_front();
        n_cmp++; if (instr_valid !== e.valid || instr_out !== e.instr) begin
          n_err++; $display("FAIL load4_fetch_on_last got=%h/%b exp=%h/%b", instr_out, instr_valid, e.instr, e.valid);
        end
      end
    end
    load_valid = 1'b0; load_last = 1'b0; fetch_en = 1'b0;
    model_run = 1'b1; model_len = 4;
    #1;
    n_cmp++; if ({load_busy, load_ready, load_err} !== 3'b000) begin n_err++; $display("FAIL load4_flags got=%b exp=000", {load_busy, load_ready, load_err}); end
    n_cmp++; if (prog_len !== 6'd4) begin n_err++; $display("FAIL load4_prog_len got=%0d exp=4", prog_len); end
    for (int i = 0; i < 8; i++) begin
      fetch_en = 1'b1; pc = pcs[i]; sb.push_back(model_fetch(pcs[i]));
      tick();
      e = sb.pop_front();
      n_cmp++; if ({instr_out, instr_valid, fetch_oob, parity_err} !== {e.instr, e.valid, e.oob, e.perr}) begin
        n_err++; $display("FAIL load4_fetch pc=%0d got=%h/%b/%b/%b exp=%h/%b/%b/%b", pcs[i],
          instr_out, instr_valid, fetch_oob, parity_err, e.instr, e.valid, e.oob, e.perr);
      end
    end
    fetch_en = 1'b0;
  endtask

  task automatic test_overflow();
    logic [PC_BITS-1:0] pcs [4];
    exp_t e;
    pcs = '{6'd0, 6'd62, 6'd63, 6'd30};
    start_load();
    for (int i = 0; i < DEPTH; i++) begin
      load_valid = 1'b1; load_last = 1'b0; load_data = WORD_W'($urandom_range(0, 65535));
      model_mem[i] = load_data; model_pbad[i] = 1'b0;
      tick();
    end
    n_cmp++; if (load_ready !== 1'b0) begin n_err++; $display("FAIL ovf_ready_33rd got=%b exp=0", load_ready); end
    n_cmp++; if (load_err !== 1'b1) begin n_err++; $display("FAIL ovf_load_err got=%b exp=1", load_err); end
    tick();
    load_valid = 1'b0;
    model_run = 1'b1; model_len = DEPTH;
    n_cmp++; if (prog_len !== 6'd32) begin n_err++; $display("FAIL ovf_prog_len got=%0d exp=32", prog_len); end
    for (int i = 0; i < 4; i++) begin
      fetch_en = 1'b1; pc = pcs[i]; sb.push_back(model_fetch(pcs[i]));
      tick();
      e = sb.pop_front();
      n_cmp++; if ({instr_out, instr_valid, fetch_oob} !== {e.instr, e.valid, e.oob}) begin
        n_err++; $display("FAIL ovf_fetch pc=%0d got=%h/%b/%b exp=%h/%b/%b", pcs[i],
          instr_out, instr_valid, fetch_oob, e.instr, e.valid, e.oob);
      end
    end
    fetch_en = 1'b0;
  endtask

  task automatic test_restart();
    logic [PC_BITS-1:0] pcs [3];
    exp_t e;
    pcs = '{6'd0, 6'd2, 6'd4};
    start_load();
    load_valid = 1'b1; load_last = 1'b0; load_data = 16'hAAAA; model_mem[0] = 16'hAAAA;
    tick();
    load_data = 16'hBBBB; model_mem[1] = 16'hBBBB;
    tick();
    load_start = 1'b1; load_data = 16'hDEAD;
    #1;
    n_cmp++; if (load_ready !== 1'b0) begin n_err++; $display("FAIL restart_ready_low got=%b exp=0", load_ready); end
    tick();
    load_start = 1'b0; load_data = 16'hCCCC; load_last = 1'b1;
    model_mem[0] = 16'hCCCC; model_pbad[0] = 1'b0;
    tick();
    load_valid = 1'b0; load_last = 1'b0;
    model_run = 1'b1; model_len = 1;
    n_cmp++; if (prog_len !== 6'd1 || load_err !== 1'b0) begin
      n_err++; $display("FAIL restart_len_err got=%0d/%b exp=1/0", prog_len, load_err);
    end
    for (int i = 0; i < 3; i++) begin
      fetch_en = 1'b1; pc = pcs[i]; sb.push_back(model_fetch(pcs[i]));
      tick();
      e = sb.pop_front();
      n_cmp++; if ({instr_out, instr_valid, fetch_oob} !== {e.instr, e.valid, e.oob}) begin
        n_err++; $display("FAIL restart_fetch pc=%0d got=%h/%b/%b exp=%h/%b/%b", pcs[i],
          instr_out, instr_valid, fetch_oob, e.instr, e.valid, e.oob);
      end
    end
    fetch_en = 1'b0;
  endtask

`ifdef INSMEM_PARITY_EN
  task automatic test_parity();
    exp_t e;
    start_load();
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1; load_last = (i == 3); load_data = WORD_W'(16'h5A00 + 3 * i);
      par_inject = (i == 2);
      model_mem[i] = load_data; model_pbad[i] = (i == 2);
      tick();
    end
    load_valid = 1'b0; load_last = 1'b0; par_inject = 1'b0;
    model_run = 1'b1; model_len = 4;
    for (int i = 0; i < 4; i++) begin
      fetch_en = 1'b1; pc = PC_BITS'(2 * i); sb.push_back(model_fetch(PC_BITS'(2 * i)));
      tick();
      e = sb.pop_front();
      n_cmp++; if ({instr_out, instr_valid, parity_err} !== {e.instr, e.valid, e.perr}) begin
        n_err++; $display("FAIL parity_fetch idx=%0d got=%h/%b/%b exp=%h/%b/%b", i,
          instr_out, instr_valid, parity_err, e.instr, e.valid, e.perr);
      end
    end
    fetch_en = 1'b0;
  endtask
`endif

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i] = '0; model_pbad[i] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clka);
    #1;
    rst_n = 1'b1;
    #1;
    test_reset();
    test_reset_mid_load();
    test_load4();
    test_overflow();
    test_restart();
`ifdef INSMEM_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/insmem_loadable.md
# insmem_loadable

Parametrised instruction memory with an on-chip program loader. A host streams instruction words in through a valid/ready port, and the block records the program length. It then serves registered, single-cycle-latency fetches to the core's PC, returning zero (NOP) outside the loaded program. It replaces the fixed 16-bit, two-clock instruction store: the word width and depth are generalised, there is a single clock, and the load FSM, bounds checking and optional parity protection are new.

## Interface
Parameters:
- WORD_W, 16, instruction width in bits.
- PC_BITS, 6, byte-address PC width; the word index is pc[PC_BITS-1:1] and DEPTH = 2**(PC_BITS-1) words.

Ports:
- clka  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load_start  in  1  pulse that (re)starts a program load.
- load_valid  in  1  load_data is valid.
- load_data  in  WORD_W  instruction word to store.
- load_last  in  1  marks the final word of the program; qualified by load_valid.
- load_ready  out  1  block accepts a word this cycle.
- load_busy  out  1  FSM is in LOAD.
- load_err  out  1  sticky overflow flag.
- prog_len  out  PC_BITS  number of words loaded.
- fetch_en  in  1  fetch request.
- pc  in  PC_BITS  byte address; bit 0 is ignored.
- instr_out  out  WORD_W  registered instruction.
- instr_valid  out  1  instr_out is valid.
- fetch_oob  out  1  the fetch was at or beyond prog_len.
- par_inject  in  1  flips the stored parity bit of the next written word; ignored without the macro.
- parity_err  out  1  parity mismatch on this fetch.

## Operation
- FSM states:
  - EMPTY: the reset state.
  - LOAD.
  - RUN.
- State transitions:
  - EMPTY or RUN, on load_start → LOAD. Write pointer wptr ← 0, load_err ← 0, prog_len ← 0.
  - LOAD, on load_start → LOAD again (restart). wptr ← 0, and any same-cycle word is dropped.
  - LOAD, on an accepted word (load_valid & load_ready) → mem[wptr] ← load_data, wptr ← wptr+1.
  - If that word has load_last set → RUN, prog_len ← wptr+1.
  - If the word is written to slot DEPTH-1 without load_last → RUN, prog_len ← DEPTH, load_err ← 1.
- load_ready = 1 exactly when the state is LOAD and load_start is low.
- Fetch behaviour by state:
  - RUN: a fetch with index < prog_len returns mem[index], with fetch_oob=0.
  - RUN: a fetch with index ≥ prog_len returns 0, with fetch_oob=1.
  - EMPTY or LOAD: a fetch returns instr_out=0 and instr_valid=0.
- Memory contents are not reset. Only control state, pointers, flags and outputs are reset.
- A reset in the middle of a load returns the FSM to EMPTY. prog_len is 0, so the partial program is unreachable.
- Width rules:
  - wptr and prog_len are PC_BITS wide, so they can hold DEPTH.
  - The index comparison is unsigned and zero-extends pc[PC_BITS-1:1].

## Timing
- Reset values:
  - state EMPTY.
  - load_ready 0, load_busy 0, load_err 0, prog_len 0.
  - instr_out 0, instr_valid 0, fetch_oob 0, parity_err 0.
- Fetch latency is 1 cycle. The request is sampled at edge N; instr_out, instr_valid, fetch_oob and parity_err are valid after edge N, until the next edge.
- instr_valid = the registered fetch_en & (state == RUN).
- A fetch in the cycle that accepts load_last sees the state as LOAD and returns invalid. The first valid fetch is issued in the cycle after the transition to RUN.
- load_busy and load_ready rise the cycle after load_start and fall the cycle after the final word is accepted.
- The load port sustains 1 word per cycle.

## Configuration
- Macro: INSMEM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit, written as ^load_data XOR par_inject.
  - On a valid, in-bounds fetch the parity is recomputed. parity_err is asserted with instr_valid on a mismatch.
  - instr_out still carries the stored data.
- Undefined:
  - No parity storage.
  - parity_err is tied to 0 and par_inject is unused.

## Structure
- Package insmem_pkg holds:
  - the state enum {ST_EMPTY, ST_LOAD, ST_RUN}.
  - the parity function.
  - the localparam expression for DEPTH.
- Sub-module insmem_loader holds the FSM, wptr, prog_len, load_err and the write-enable/address generation.
- The top level holds the storage array and the fetch register.

## Test plan
- Reset mid-load after 3 words → state EMPTY, prog_len=0. A fetch at pc=0 gives instr_valid=0 and instr_out=0.
- Load 4 words {0x1111, 0x2222, 0x3333, 0x4444}, last on the 4th → prog_len=4. A fetch at pc=6 gives 0x4444 one cycle later. A fetch at pc=7 also gives 0x4444 (bit 0 ignored).
- A fetch at pc=8 after the 4-word load → instr_out=0, fetch_oob=1, instr_valid=1.
- Stream 32 words with no load_last (PC_BITS=6) → all 32 words accepted, load_err=1, prog_len=32. The 33rd load_valid sees load_ready=0.
- load_start asserted during a load, with load_valid high in the same cycle → that word is dropped and wptr restarts at 0. The next accepted word lands at index 0.
- With INSMEM_PARITY_EN: write word 2 with par_inject=1 → a fetch at pc=4 gives parity_err=1. Fetches of other words give parity_err=0.
